cn_q_monitor: RTL
=================

# cn_q_monitor

Downstream observer for the CN (change/no-change) flip-flop: consumes its `q`/`qbar` pair and, over a programmable window of clock cycles, counts rising and falling transitions, tracks the longest constant run, and flags any cycle where the outputs fail to be complementary. Results are presented through a valid/ready handshake so a bench checker or status register block can collect them. It is the characterisation stage placed directly after the CN flip-flop in the flip-flop test chain.

## Interface
Parameters:
- `WIN`, 16: window length in sampled cycles; legal range 1..255.
- `CNT_W`, 4: width of every result counter; all counters saturate at 2^CNT_W-1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `q_in`  in  1  CN flip-flop `q`.
- `qbar_in`  in  1  CN flip-flop `qbar`.
- `start`  in  1  one-cycle request to begin a window; honoured only in IDLE.
- `busy`  out  1  high in COUNT and REPORT.
- `res_valid`  out  1  results stable and valid (REPORT).
- `res_ready`  in  1  consumer accepts results.
- `rise_cnt`  out  CNT_W  0→1 transitions of `q_in` within the window.
- `fall_cnt`  out  CNT_W  1→0 transitions of `q_in` within the window.
- `max_run`  out  CNT_W  longest run of identical consecutive `q_in` samples.
- `comp_err`  out  1  sticky: some sample had `q_in == qbar_in`.

## Operation
- States: IDLE, COUNT, REPORT.
- Reset (`rst_n`=0 at a clock edge): state IDLE; `busy`, `res_valid`, `comp_err` = 0; `rise_cnt`, `fall_cnt`, `max_run` = 0; internal window counter, run counter, `q_prev` = 0. Applies from any state; an in-progress window is discarded, no partial result presented.
- IDLE: `start`=1 → COUNT; same edge clears all result counters and `comp_err`, loads window counter with WIN-1. With `start`=0, outputs hold the last results and `res_valid` stays 0.
- COUNT: one sample of `q_in`/`qbar_in` per cycle, exactly WIN samples.
  - First sample: loads `q_prev`, run counter = 1, `max_run` = 1; no edge counted.
  - Later samples: `q_prev`=0 & `q_in`=1 → `rise_cnt`+1; `q_prev`=1 & `q_in`=0 → `fall_cnt`+1; equal → run+1, else run = 1; `max_run` = max(`max_run`, updated run).
  - Any sample with `q_in == qbar_in` sets `comp_err` (counters still update from `q_in`).
  - Window counter reaching 0 on a sample → REPORT at that edge.
  - `start` ignored.
- REPORT: `res_valid`=1; all result outputs frozen. `res_valid & res_ready` at an edge → IDLE, `res_valid` drops next cycle; results remain visible in IDLE. `start` ignored, including when coincident with `res_ready`; must be re-asserted in IDLE.
- Arithmetic: all counters saturate at 2^CNT_W-1 (no wrap); internal run counter saturates identically, so `max_run` ≤ 2^CNT_W-1.

## Timing
- `start` sampled high in IDLE at edge k → `busy`=1 from k; samples taken at edges k+1 .. k+WIN; `res_valid`=1 from edge k+WIN.
- Start-to-valid latency: WIN cycles; earliest restart: cycle after handshake edge → minimum period WIN+2 cycles.
- `res_ready` may be held high permanently; REPORT then lasts exactly one cycle.
- WIN=1: single sample, `rise_cnt`=`fall_cnt`=0, `max_run`=1.
- No combinational path from any input to any output; all outputs registered.

## Structure
- Package `cn_pkg`: state enum typedef (`cn_mon_state_t`: IDLE, COUNT, REPORT), default constants `CN_MON_WIN`=16, `CN_MON_CNT_W`=4.
- Sub-module `cn_sat_counter` (parameter W; inputs clr, inc; output saturating count), instantiated for `rise_cnt`, `fall_cnt`, and the run counter; FSM, window counter and `max_run` compare remain in the top.

## Test plan
- Reset mid-COUNT: `rst_n`=0 after 5 samples → next cycle state IDLE, `busy`=0, `res_valid`=0, all counters 0.
- WIN=16, `q_in` toggling every cycle from 0, `qbar_in`=~`q_in` → `res_valid` 16 cycles after `start`; `rise_cnt`=8, `fall_cnt`=7, `max_run`=1, `comp_err`=0.
- WIN=16, CNT_W=4, `q_in` constant 1 → `rise_cnt`=0, `fall_cnt`=0, `max_run`=15 (saturated, not 0).
- Pattern 0,0,1,1,1,0 then 0 for rest, `qbar_in` tied equal to `q_in` in sample 3 only → `rise_cnt`=1, `fall_cnt`=1, `max_run`=11, `comp_err`=1.
- `res_ready` held 0 for 10 cycles in REPORT with `start` pulsing → outputs frozen, `res_valid` stays 1, no new window; `res_ready`=1 with `start`=1 same cycle → IDLE, `busy`=0, no window started.
- WIN=1 back-to-back: `start`, sample, REPORT, handshake, `start` again → two results with `max_run`=1, period 3 cycles.

Source files
------------

// File: rtl/cn_pkg.sv
// Shared types and defaults for the CN flip-flop output monitor.
// Holds the monitor state enum and default window/counter sizes.
package cn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    REPORT
  } cn_mon_state_t;

  localparam int CN_MON_WIN   = 16;
  localparam int CN_MON_CNT_W = 4;

endpackage

// File: rtl/cn_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// Ports: clk, rst_n, clr (clear; with inc loads 1), inc, count.
module cn_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  // clr+inc restarts the count at one (start of a fresh run)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && count != MAX) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cn_q_monitor.sv
// Windowed observer of CN flip-flop q/qbar: edge counts, longest run,
// complement error. Ports: clk, rst_n, q_in, qbar_in, start, busy,
// res_valid, res_ready, rise_cnt, fall_cnt, max_run, comp_err.
module cn_q_monitor
  import cn_pkg::*;
#(
  parameter int WIN   = CN_MON_WIN,
  parameter int CNT_W = CN_MON_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_in,
  input  logic             qbar_in,
  input  logic             start,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] max_run,
  output logic             comp_err
);

  localparam logic [7:0]       WIN_M1 = 8'(WIN - 1);
  localparam logic [CNT_W-1:0] MAX    = '1;

  cn_mon_state_t    state;
  cn_mon_state_t    nxt;
  logic [7:0]       win_cnt;
  logic             q_prev;
  logic [CNT_W-1:0] run;
  logic [CNT_W-1:0] run_upd;
  logic             start_go;
  logic             sample;
  logic             first;
  logic             diff;
  logic             last;

  assign start_go = (state == IDLE) && start;
  assign sample   = (state == COUNT);
  assign first    = sample && (win_cnt == WIN_M1);
  assign last     = sample && (win_cnt == 8'd0);
  assign diff     = q_in != q_prev;

  // run length after this sample; feeds the max compare directly
  always_comb begin
    run_upd = '0;
    if (first || diff) begin
      run_upd = CNT_W'(1);
    end else if (run == MAX) begin
      run_upd = MAX;
    end else begin
      run_upd = run + CNT_W'(1);
    end
  end

  cn_sat_counter #(.W(CNT_W)) u_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_go),
    .inc   (sample && !first && !q_prev && q_in),
    .count (rise_cnt)
  );

  cn_sat_counter #(.W(CNT_W)) u_fall (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_go),
    .inc   (sample && !first && q_prev && !q_in),
    .count (fall_cnt)
  );

  cn_sat_counter #(.W(CNT_W)) u_run (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_go || (sample && (first || diff))),
    .inc   (sample),
    .count (run)
  );

  always_comb begin
    nxt       = state;
    busy      = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nxt = COUNT;
      end
      COUNT: begin
        busy = 1'b1;
        if (last) nxt = REPORT;
      end
      REPORT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      win_cnt  <= '0;
      q_prev   <= 1'b0;
      max_run  <= '0;
      comp_err <= 1'b0;
    end else begin
      state <= nxt;
      if (start_go) begin
        win_cnt  <= WIN_M1;
        max_run  <= '0;
        comp_err <= 1'b0;
      end else if (sample) begin
        if (!last) win_cnt <= win_cnt - 8'd1;
        q_prev <= q_in;
        if (run_upd > max_run) max_run <= run_upd;
        if (q_in == qbar_in) comp_err <= 1'b1;
      end
    end
  end

endmodule
